// File: rtl/adc_stream_pkg.sv
// Shared ADC stream definitions: frame word indices, CRC-16-CCITT constants and
// the single-bit CRC update used by both the transmit packer and the receive checker.
package adc_stream_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam int unsigned ADC_STATUS_WORD_IDX  = 0;
   localparam int unsigned ADC_CH0_WORD_IDX     = 1;
   localparam int unsigned ADC_NUM_CHANNELS     = 8;
   localparam int unsigned ADC_NUM_SAMPLE_WORDS = ADC_NUM_CHANNELS + 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } tx_state_t;

   // MSB-first CRC-16-CCITT step, no reflection.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic w_fb;
      w_fb = crc[15] ^ din;
      crc16_step = {crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/adc_frame_pack_tx_if.sv
// Sample-set input handshake and serial bit stream of the ADC frame packer.
interface adc_frame_pack_tx_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] status_word;
   logic [31:0] ch0;
   logic [31:0] ch1;
   logic [31:0] ch2;
   logic [31:0] ch3;
   logic [31:0] ch4;
   logic [31:0] ch5;
   logic [31:0] ch6;
   logic [31:0] ch7;
   logic        bit_valid;
   logic        bit_ready;
   logic        dout;
   logic        sof;
   logic        eof;
   logic        busy;
   logic        frame_done;

   // Environment side: offers sample sets and sinks the bit stream.
   modport master (
      output in_valid, status_word, ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7, bit_ready,
      input  in_ready, bit_valid, dout, sof, eof, busy, frame_done
   );

   // Packer side.
   modport slave (
      input  in_valid, status_word, ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7, bit_ready,
      output in_ready, bit_valid, dout, sof, eof, busy, frame_done
   );

endinterface

// File: rtl/adc_crc16_ccitt_serial.sv
// Bit-serial CRC-16-CCITT accumulator; init has priority over en.
module adc_crc16_ccitt_serial
   import adc_stream_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] r_crc;

   always_ff @(posedge clk) begin
      if (rst || init) begin
         r_crc <= CRC16_INIT;
      end else if (en) begin
         r_crc <= crc16_step(r_crc, din);
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/adc_frame_pack_tx.sv
// Captures one STATUS+CH0..CH7 sample set, truncates to the wire width, appends an
// optional CRC-16 word and serializes the frame MSB-first on a bit valid/ready stream.
module adc_frame_pack_tx
   import adc_stream_pkg::*;
#(
   parameter int unsigned BITS_PER_WORD   = 24,
   parameter int unsigned WORDS_PER_FRAME = 10,
   parameter bit          CRC_EN          = 1'b1
) (
   input  logic clk,
   input  logic rst,
   adc_frame_pack_tx_if.slave bus
);

   localparam int unsigned BPW = BITS_PER_WORD;
   localparam int unsigned WPF = WORDS_PER_FRAME;
   localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned WIW = $clog2(WPF);
   localparam int unsigned SIW = $clog2(ADC_NUM_SAMPLE_WORDS);

   tx_state_t        r_state;
   logic [BPW-1:0]   r_words [ADC_NUM_SAMPLE_WORDS];
   logic [BPW-1:0]   r_shift;
   logic [BIW-1:0]   r_bit_idx;
   logic [WIW-1:0]   r_word_idx;
   logic             r_in_ready;
   logic             r_bit_valid;
   logic             r_sof;
   logic             r_eof;
   logic             r_busy;
   logic             r_frame_done;

   tx_state_t        w_state_nxt;
   logic [BPW-1:0]   w_shift_nxt;
   logic [BIW-1:0]   w_bit_idx_nxt;
   logic [WIW-1:0]   w_word_idx_nxt;
   logic             w_in_ready_nxt;
   logic             w_bit_valid_nxt;
   logic             w_sof_nxt;
   logic             w_eof_nxt;
   logic             w_busy_nxt;
   logic             w_frame_done_nxt;

   logic [BPW-1:0]   w_in_words [ADC_NUM_SAMPLE_WORDS];
   logic             w_capture;
   logic             w_accept;
   logic             w_bit;
   logic             w_crc_en;
   logic [15:0]      w_crc;
   logic [15:0]      w_crc_step;
   logic [47:0]      w_crc_wide;
   logic [BPW-1:0]   w_crc_word;
   logic [WIW-1:0]   w_word_inc;
   logic [SIW-1:0]   w_sel;
   logic [BPW-1:0]   w_next_word;

   assign w_capture  = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
   assign w_accept   = r_bit_valid && bus.bit_ready;
   assign w_bit      = r_shift[BPW-1];
   assign w_crc_en   = w_accept && (r_word_idx < WIW'(WPF - 1));
   assign w_word_inc = WIW'(r_word_idx + 1'b1);

   // The CRC word is loaded on the same edge the last covered bit is accepted,
   // so it must already include that bit.
   assign w_crc_step = crc16_step(w_crc, w_bit);
   assign w_crc_wide = {w_crc_step, 32'h0000_0000};
   assign w_crc_word = BPW'(w_crc_wide >> (48 - BPW));

   adc_crc16_ccitt_serial u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (w_capture),
      .en   (w_crc_en),
      .din  (w_bit),
      .crc  (w_crc)
   );

   always_comb begin
      w_in_words[ADC_STATUS_WORD_IDX]  = BPW'(bus.status_word);
      w_in_words[ADC_CH0_WORD_IDX + 0] = BPW'(bus.ch0);
      w_in_words[ADC_CH0_WORD_IDX + 1] = BPW'(bus.ch1);
      w_in_words[ADC_CH0_WORD_IDX + 2] = BPW'(bus.ch2);
      w_in_words[ADC_CH0_WORD_IDX + 3] = BPW'(bus.ch3);
      w_in_words[ADC_CH0_WORD_IDX + 4] = BPW'(bus.ch4);
      w_in_words[ADC_CH0_WORD_IDX + 5] = BPW'(bus.ch5);
      w_in_words[ADC_CH0_WORD_IDX + 6] = BPW'(bus.ch6);
      w_in_words[ADC_CH0_WORD_IDX + 7] = BPW'(bus.ch7);
   end

   // Content of the word that follows the current one.
   always_comb begin
      w_sel       = SIW'(w_word_inc);
      w_next_word = '0;
      if (w_word_inc < WIW'(ADC_NUM_SAMPLE_WORDS)) begin
         w_next_word = r_words[w_sel];
      end else if (CRC_EN && (w_word_inc == WIW'(WPF - 1))) begin
         w_next_word = w_crc_word;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_bit_idx_nxt    = r_bit_idx;
      w_word_idx_nxt   = r_word_idx;
      w_in_ready_nxt   = 1'b0;
      w_bit_valid_nxt  = r_bit_valid;
      w_sof_nxt        = r_sof;
      w_eof_nxt        = 1'b0;
      w_busy_nxt       = r_busy;
      w_frame_done_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_in_ready_nxt = 1'b1;
            if (w_capture) begin
               w_state_nxt     = ST_SHIFT;
               w_shift_nxt     = w_in_words[ADC_STATUS_WORD_IDX];
               w_bit_idx_nxt   = '0;
               w_word_idx_nxt  = '0;
               w_in_ready_nxt  = 1'b0;
               w_bit_valid_nxt = 1'b1;
               w_sof_nxt       = 1'b1;
               w_busy_nxt      = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_accept) begin
               w_sof_nxt = 1'b0;
               if (r_bit_idx == BIW'(BPW - 1)) begin
                  w_bit_idx_nxt = '0;
                  if (r_word_idx == WIW'(WPF - 1)) begin
                     w_state_nxt      = ST_IDLE;
                     w_word_idx_nxt   = '0;
                     w_in_ready_nxt   = 1'b1;
                     w_bit_valid_nxt  = 1'b0;
                     w_busy_nxt       = 1'b0;
                     w_frame_done_nxt = 1'b1;
                  end else begin
                     w_word_idx_nxt = w_word_inc;
                     w_shift_nxt    = w_next_word;
                  end
               end else begin
                  w_bit_idx_nxt = BIW'(r_bit_idx + 1'b1);
                  w_shift_nxt   = r_shift << 1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_state_nxt == ST_SHIFT) begin
         w_eof_nxt = (w_word_idx_nxt == WIW'(WPF - 1)) && (w_bit_idx_nxt == BIW'(BPW - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bit_idx    <= '0;
         r_word_idx   <= '0;
         r_in_ready   <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_sof        <= 1'b0;
         r_eof        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_word_idx   <= w_word_idx_nxt;
         r_in_ready   <= w_in_ready_nxt;
         r_bit_valid  <= w_bit_valid_nxt;
         r_sof        <= w_sof_nxt;
         r_eof        <= w_eof_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   // Sample words are held only as data; the FSM decides when they are read.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int i = 0; i < int'(ADC_NUM_SAMPLE_WORDS); i++) begin
            r_words[i] <= w_in_words[i];
         end
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.dout       = r_shift[BPW-1];
   assign bus.sof        = r_sof;
   assign bus.eof        = r_eof;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule
